// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared types and constants for the AXI4-Lite round-robin arbiter
package axil_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int NUM_M_MAX = 4;
endpackage

// File: rtl/axil_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or above rr_ptr with wrap
module rr_pick #(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0]         req,
  input  logic [$clog2(NUM_M)-1:0] rr_ptr,
  output logic [$clog2(NUM_M)-1:0] winner,
  output logic                     any
);
  localparam int W = $clog2(NUM_M);
  // scan from farthest to nearest so the requester closest to rr_ptr is kept
  always_comb begin
    winner = '0;
    for (int k = NUM_M - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NUM_M]) winner = W'((int'(rr_ptr) + k) % NUM_M);
  end
  assign any = |req;
endmodule

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: round-robin sharing of one AXI4-Lite slave; AXIL_ARB_TIMEOUT_EN adds a response watchdog
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_M          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_M*ADDRESS-1:0]     S_AWADDR,
  input  logic [NUM_M-1:0]             S_AWVALID,
  output logic [NUM_M-1:0]             S_AWREADY,
  input  logic [NUM_M*DATA_WIDTH-1:0]  S_WDATA,
  input  logic [NUM_M*DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic [NUM_M-1:0]             S_WVALID,
  output logic [NUM_M-1:0]             S_WREADY,
  output logic [1:0]                   S_BRESP,
  output logic [NUM_M-1:0]             S_BVALID,
  input  logic [NUM_M-1:0]             S_BREADY,
  input  logic [NUM_M*ADDRESS-1:0]     S_ARADDR,
  input  logic [NUM_M-1:0]             S_ARVALID,
  output logic [NUM_M-1:0]             S_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic [NUM_M-1:0]             S_RVALID,
  input  logic [NUM_M-1:0]             S_RREADY,
  output logic [ADDRESS-1:0]           M_AWADDR,
  output logic                         M_AWVALID,
  input  logic                         M_AWREADY,
  output logic [DATA_WIDTH-1:0]        M_WDATA,
  output logic [DATA_WIDTH/8-1:0]      M_WSTRB,
  output logic                         M_WVALID,
  input  logic                         M_WREADY,
  input  logic [1:0]                   M_BRESP,
  input  logic                         M_BVALID,
  output logic                         M_BREADY,
  output logic [ADDRESS-1:0]           M_ARADDR,
  output logic                         M_ARVALID,
  input  logic                         M_ARREADY,
  input  logic [DATA_WIDTH-1:0]        M_RDATA,
  input  logic [1:0]                   M_RRESP,
  input  logic                         M_RVALID,
  output logic                         M_RREADY,
  output logic [$clog2(NUM_M)-1:0]     grant_id,
  output logic                         busy
);
  localparam int W = $clog2(NUM_M);
  localparam int SW = DATA_WIDTH / 8;
  state_t state;
  logic [W-1:0] rr_ptr, winner, next_ptr;
  logic [NUM_M-1:0] req, g_oh;
  logic any_req, aw_done, w_done, aw_fwd, w_fwd, aw_hs, w_hs, b_up, r_up, b_done, r_done;
  logic to_fired, absorb;
  assign req = S_AWVALID | S_ARVALID;
  rr_pick #(.NUM_M(NUM_M)) u_pick (.req(req), .rr_ptr(rr_ptr), .winner(winner), .any(any_req));
  // one-hot mask of the current owner for per-master handshakes
  always_comb begin
    g_oh = '0;
    g_oh[grant_id] = 1'b1;
  end
  assign next_ptr = grant_id == W'(NUM_M - 1) ? '0 : grant_id + 1'b1;
  assign busy = state != IDLE;
  assign aw_fwd = state == WR_ADDR && !aw_done;
  assign w_fwd = state == WR_ADDR && !w_done;
  assign M_AWVALID = aw_fwd & S_AWVALID[grant_id];
  assign M_AWADDR = aw_fwd ? S_AWADDR[int'(grant_id)*ADDRESS +: ADDRESS] : '0;
  assign S_AWREADY = aw_fwd && M_AWREADY ? g_oh : '0;
  assign M_WVALID = w_fwd & S_WVALID[grant_id];
  assign M_WDATA = w_fwd ? S_WDATA[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign M_WSTRB = w_fwd ? S_WSTRB[int'(grant_id)*SW +: SW] : '0;
  assign S_WREADY = w_fwd && M_WREADY ? g_oh : '0;
  assign aw_hs = M_AWVALID & M_AWREADY;
  assign w_hs = M_WVALID & M_WREADY;
  assign b_up = state == WR_RESP && (to_fired || M_BVALID);
  assign b_done = b_up & S_BREADY[grant_id];
  assign S_BVALID = b_up ? g_oh : '0;
  assign S_BRESP = state != WR_RESP ? RESP_OKAY : to_fired ? RESP_SLVERR : M_BRESP;
  assign M_BREADY = state == WR_RESP ? (to_fired | S_BREADY[grant_id]) : absorb && state == IDLE;
  assign M_ARVALID = state == RD_ADDR & S_ARVALID[grant_id];
  assign M_ARADDR = state == RD_ADDR ? S_ARADDR[int'(grant_id)*ADDRESS +: ADDRESS] : '0;
  assign S_ARREADY = state == RD_ADDR && M_ARREADY ? g_oh : '0;
  assign r_up = state == RD_DATA && (to_fired || M_RVALID);
  assign r_done = r_up & S_RREADY[grant_id];
  assign S_RVALID = r_up ? g_oh : '0;
  assign S_RDATA = state == RD_DATA && !to_fired ? M_RDATA : '0;
  assign S_RRESP = state != RD_DATA ? RESP_OKAY : to_fired ? RESP_SLVERR : M_RRESP;
  assign M_RREADY = state == RD_DATA ? (to_fired | S_RREADY[grant_id]) : absorb && state == IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  assign to_fired = to_cnt == CW'(TIMEOUT_CYCLES);
  assign absorb = ARESETN;
  // watchdog: zero outside response phases, counts response-phase cycles with no downstream answer
  always_ff @(posedge ACLK) begin
    if (!ARESETN || !(state == WR_RESP || state == RD_DATA)) to_cnt <= '0;
    else if (!to_fired && !(state == WR_RESP ? M_BVALID : M_RVALID)) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_fired = 1'b0;
  assign absorb = 1'b0;
`endif
  // transaction-level FSM: arbitrate in IDLE, own the slave until the response completes
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_id <= winner;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          state <= S_AWVALID[winner] ? WR_ADDR : RD_ADDR;
        end
        WR_ADDR: begin
          aw_done <= aw_done | aw_hs;
          w_done <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: if (b_done) begin
          state <= IDLE;
          rr_ptr <= next_ptr;
        end
        RD_ADDR: if (M_ARVALID && M_ARREADY) state <= RD_DATA;
        RD_DATA: if (r_done) begin
          state <= IDLE;
          rr_ptr <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: directed self-checking bench for axil_rr_arbiter with two masters
module tb_axil_rr_arbiter;
  import axil_arb_pkg::*;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [63:0] S_AWADDR, S_WDATA, S_ARADDR;
  logic [7:0] S_WSTRB;
  logic [1:0] S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BRESP, S_BVALID, S_BREADY;
  logic [1:0] S_ARVALID, S_ARREADY, S_RRESP, S_RVALID, S_RREADY;
  logic [31:0] S_RDATA, M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0] M_WSTRB;
  logic M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, busy;
  logic [1:0] M_BRESP, M_RRESP;
  logic [0:0] grant_id;
  int cmp = 0, err = 0, aw_hs_n = 0, w_hs_n = 0;

  axil_rr_arbiter #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_M(2), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (M_AWVALID && M_AWREADY) aw_hs_n++;
    if (M_WVALID && M_WREADY) w_hs_n++;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    step();
    step();
    cmp++; if ({busy, grant_id} !== 2'b00) begin err++; $display("FAIL reset_busy_grant: got %b want 00", {busy, grant_id}); end
    cmp++; if (dut.rr_ptr !== 1'b0) begin err++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
    cmp++; if ({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY} !== 5'b0) begin err++; $display("FAIL reset_m_hs: got %b want 00000", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}); end
    cmp++; if ({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID} !== 10'b0) begin err++; $display("FAIL reset_s_hs: got %b want 0", {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID}); end
    cmp++; if ({M_AWADDR, M_WDATA, M_ARADDR, S_RDATA} !== 128'b0) begin err++; $display("FAIL reset_payload: got %h want 0", {M_AWADDR, M_WDATA, M_ARADDR, S_RDATA}); end
    ARESETN = 1'b1;
    step();
  endtask

  task automatic test_write();
    S_AWADDR[31:0] = 32'h10; S_AWVALID[0] = 1'b1;
    S_WDATA[31:0] = 32'hDEADBEEF; S_WSTRB[3:0] = 4'hF; S_WVALID[0] = 1'b1;
    #1;
    cmp++; if (M_AWVALID !== 1'b0) begin err++; $display("FAIL wr_latency: got %b want 0", M_AWVALID); end
    step();
    cmp++; if ({M_AWVALID, M_WVALID, busy, grant_id} !== 4'b1110) begin err++; $display("FAIL wr_fwd: got %b want 1110", {M_AWVALID, M_WVALID, busy, grant_id}); end
    cmp++; if ({M_AWADDR, M_WDATA, M_WSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin err++; $display("FAIL wr_payload: got %h want 10deadbeeff", {M_AWADDR, M_WDATA, M_WSTRB}); end
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    #1;
    cmp++; if ({S_AWREADY, S_WREADY} !== 4'b0101) begin err++; $display("FAIL wr_ready: got %b want 0101", {S_AWREADY, S_WREADY}); end
    step();
    S_AWVALID[0] = 1'b0; S_WVALID[0] = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
    M_BVALID = 1'b1; M_BRESP = RESP_OKAY; S_BREADY[0] = 1'b1;
    #1;
    cmp++; if ({S_BVALID, S_BRESP, M_BREADY, M_AWVALID} !== 6'b010010) begin err++; $display("FAIL wr_resp: got %b want 010010", {S_BVALID, S_BRESP, M_BREADY, M_AWVALID}); end
    step();
    M_BVALID = 1'b0; S_BREADY = 2'b00;
    cmp++; if ({busy, dut.rr_ptr} !== 2'b01) begin err++; $display("FAIL wr_done_ptr: got %b want 01", {busy, dut.rr_ptr}); end
  endtask

  task automatic test_rr_reads();
    int exp_g[4] = '{1, 0, 1, 0};
    int n = 0;
    S_ARADDR = {32'h200, 32'h100}; S_ARVALID = 2'b11; M_ARREADY = 1'b1;
    M_RVALID = 1'b1; M_RDATA = 32'h12345678; M_RRESP = RESP_OKAY; S_RREADY = 2'b11;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (M_ARVALID && M_ARREADY) begin
        cmp++; if (grant_id !== 1'(exp_g[n])) begin err++; $display("FAIL rr_grant%0d: got %0d want %0d", n, grant_id, exp_g[n]); end
        cmp++; if (M_ARADDR !== (exp_g[n] == 1 ? 32'h200 : 32'h100)) begin err++; $display("FAIL rr_addr%0d: got %h", n, M_ARADDR); end
        n++;
      end
    end
    cmp++; if (n !== 4) begin err++; $display("FAIL rr_count: got %0d want 4", n); end
    step();
    S_ARVALID = 2'b00;
    cmp++; if ({S_RVALID, S_RDATA} !== {2'b01, 32'h12345678}) begin err++; $display("FAIL rr_rdata: got %h want 112345678", {S_RVALID, S_RDATA}); end
    step();
    M_RVALID = 1'b0; S_RREADY = 2'b00; M_ARREADY = 1'b0;
    cmp++; if ({busy, dut.rr_ptr} !== 2'b01) begin err++; $display("FAIL rr_end: got %b want 01", {busy, dut.rr_ptr}); end
  endtask

  task automatic test_write_then_read();
    int aw0 = aw_hs_n, w0 = w_hs_n;
    S_AWADDR[63:32] = 32'h40; S_AWVALID[1] = 1'b1;
    S_ARADDR[63:32] = 32'h44; S_ARVALID[1] = 1'b1;
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    step();
    cmp++; if ({grant_id, M_AWVALID, M_ARVALID, M_WVALID} !== 4'b1100) begin err++; $display("FAIL wtr_write_first: got %b want 1100", {grant_id, M_AWVALID, M_ARVALID, M_WVALID}); end
    step();
    S_AWVALID[1] = 1'b0;
    #1;
    cmp++; if (M_AWVALID !== 1'b0) begin err++; $display("FAIL wtr_aw_dropped: got %b want 0", M_AWVALID); end
    step();
    step();
    S_WDATA[63:32] = 32'hA5A50001; S_WSTRB[7:4] = 4'h3; S_WVALID[1] = 1'b1;
    #1;
    cmp++; if ({M_WVALID, M_WDATA, M_WSTRB, S_WREADY} !== {1'b1, 32'hA5A50001, 4'h3, 2'b10}) begin err++; $display("FAIL wtr_late_w: got %h", {M_WVALID, M_WDATA, M_WSTRB, S_WREADY}); end
    step();
    S_WVALID[1] = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
    cmp++; if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1) begin err++; $display("FAIL wtr_hs_count: got aw %0d w %0d want 1 1", aw_hs_n - aw0, w_hs_n - w0); end
    M_BVALID = 1'b1; S_BREADY[1] = 1'b1;
    step();
    M_BVALID = 1'b0; S_BREADY = 2'b00;
    step();
    cmp++; if ({grant_id, M_ARVALID, M_ARADDR} !== {1'b1, 1'b1, 32'h44}) begin err++; $display("FAIL wtr_read_next: got %h", {grant_id, M_ARVALID, M_ARADDR}); end
    M_ARREADY = 1'b1;
    step();
    S_ARVALID[1] = 1'b0; M_ARREADY = 1'b0; M_RVALID = 1'b1; S_RREADY[1] = 1'b1;
    step();
    M_RVALID = 1'b0; S_RREADY = 2'b00;
    cmp++; if ({busy, dut.rr_ptr} !== 2'b00) begin err++; $display("FAIL wtr_end: got %b want 00", {busy, dut.rr_ptr}); end
  endtask

  task automatic test_read_stall();
    S_ARADDR[63:32] = 32'h300; S_ARVALID[1] = 1'b1;
    step();
    S_ARADDR[31:0] = 32'h80; S_ARVALID[0] = 1'b1; M_ARREADY = 1'b1;
    step();
    S_ARVALID[1] = 1'b0; M_ARREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp++; if ({S_RVALID, S_ARREADY, M_ARVALID, grant_id, busy} !== 7'b0000011) begin err++; $display("FAIL stall_wait%0d: got %b want 0000011", i, {S_RVALID, S_ARREADY, M_ARVALID, grant_id, busy}); end
      step();
    end
    M_RVALID = 1'b1; M_RDATA = 32'hCAFEF00D; M_RRESP = RESP_OKAY; S_RREADY = 2'b00;
    #1;
    cmp++; if ({S_RVALID, S_RDATA, M_RREADY} !== {2'b10, 32'hCAFEF00D, 1'b0}) begin err++; $display("FAIL stall_rvalid: got %h", {S_RVALID, S_RDATA, M_RREADY}); end
    step();
    cmp++; if ({S_RVALID, S_RDATA, S_RRESP} !== {2'b10, 32'hCAFEF00D, 2'b00}) begin err++; $display("FAIL stall_hold: got %h", {S_RVALID, S_RDATA, S_RRESP}); end
    S_RREADY[1] = 1'b1;
    #1;
    cmp++; if (M_RREADY !== 1'b1) begin err++; $display("FAIL stall_rready: got %b want 1", M_RREADY); end
    step();
    M_RVALID = 1'b0; S_RREADY = 2'b00;
    cmp++; if ({busy, dut.rr_ptr} !== 2'b00) begin err++; $display("FAIL stall_end: got %b want 00", {busy, dut.rr_ptr}); end
    step();
    cmp++; if ({grant_id, M_ARVALID, M_ARADDR} !== {1'b0, 1'b1, 32'h80}) begin err++; $display("FAIL stall_m0_served: got %h", {grant_id, M_ARVALID, M_ARADDR}); end
    M_ARREADY = 1'b1;
    step();
    S_ARVALID[0] = 1'b0; M_ARREADY = 1'b0; M_RVALID = 1'b1; S_RREADY[0] = 1'b1;
    step();
    M_RVALID = 1'b0; S_RREADY = 2'b00;
  endtask

  task automatic test_reset_mid();
    S_AWADDR[31:0] = 32'h20; S_AWVALID[0] = 1'b1; S_WVALID[0] = 1'b1;
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    step();
    step();
    S_AWVALID[0] = 1'b0; S_WVALID[0] = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
    cmp++; if (dut.state !== WR_RESP) begin err++; $display("FAIL mid_same_cycle_hs: got %0d want %0d", dut.state, WR_RESP); end
    M_BVALID = 1'b1; ARESETN = 1'b0;
    step();
    cmp++; if ({busy, grant_id, dut.rr_ptr} !== 3'b000) begin err++; $display("FAIL mid_reset_state: got %b want 000", {busy, grant_id, dut.rr_ptr}); end
    cmp++; if ({S_BVALID, M_BREADY, M_AWVALID, M_WVALID, S_AWREADY, S_WREADY} !== 8'b0) begin err++; $display("FAIL mid_reset_hs: got %b want 0", {S_BVALID, M_BREADY, M_AWVALID, M_WVALID, S_AWREADY, S_WREADY}); end
    ARESETN = 1'b1; M_BVALID = 1'b0;
    step();
  endtask

`ifdef AXIL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    S_AWVALID[0] = 1'b1; S_WVALID[0] = 1'b1; M_AWREADY = 1'b1; M_WREADY = 1'b1;
    step();
    step();
    S_AWVALID[0] = 1'b0; S_WVALID[0] = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (S_BVALID[0]) n = i;
    end
    cmp++; if (n !== 8) begin err++; $display("FAIL to_cycles: got %0d want 8", n); end
    cmp++; if (S_BRESP !== RESP_SLVERR) begin err++; $display("FAIL to_bresp: got %b want 10", S_BRESP); end
    S_BREADY[0] = 1'b1;
    step();
    S_BREADY = 2'b00; M_BVALID = 1'b1;
    #1;
    cmp++; if ({busy, M_BREADY, M_RREADY, S_BVALID} !== 5'b01100) begin err++; $display("FAIL to_absorb: got %b want 01100", {busy, M_BREADY, M_RREADY, S_BVALID}); end
    step();
    M_BVALID = 1'b0;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL to_idle: got %b want 0", busy); end
  endtask
`endif

  initial begin
    S_AWADDR = '0; S_WDATA = '0; S_ARADDR = '0; S_WSTRB = '0;
    S_AWVALID = '0; S_WVALID = '0; S_BREADY = '0; S_ARVALID = '0; S_RREADY = '0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = '0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = '0;
    test_reset();
    test_write();
    test_rr_reads();
    test_write_then_read();
    test_read_stall();
    test_reset_mid();
`ifdef AXIL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
